sfm_stream_row_framer: RTL
==========================

// Module: sfm_stream_row_framer
// PURPOSE
// - Sits directly downstream of the softmax streamer load channel and upstream of the datapath.
// - Consumes TCDM data beats and frames them into rows of ROW_LEN elements.
// - Replaces out-of-row lanes with PAD_VALUE (-inf), so max/exp-sum reduction is unaffected.
// - Emits a per-beat lane mask plus end-of-row and end-of-tensor flags.
// PARAMETERS
// - DATA_WIDTH  128      beat width in bits; multiple of ELEM_WIDTH
// - ELEM_WIDTH  16       element width in bits (bf16)
// - N_ELEMS     DATA_WIDTH/ELEM_WIDTH   lanes per beat (derived, not overridable)
// - LEN_WIDTH   16       width of the row-length and row-count config fields
// - PAD_VALUE   16'hFF80 fill for invalid lanes (bf16 -inf)
// PORTS
// - clk_i          in   1               clock, all logic on rising edge
// - rst_i          in   1               synchronous reset, active-high
// - clear_i        in   1               synchronous soft clear, same effect as rst_i
// - start_i        in   1               start pulse; row_len_i/n_rows_i sampled only when accepted
// - row_len_i      in   LEN_WIDTH       elements per row
// - n_rows_i       in   LEN_WIDTH       rows in tensor
// - in_valid_i     in   1               input beat valid
// - in_ready_o     out  1               input beat accepted when valid&ready
// - in_data_i      in   DATA_WIDTH      input beat, lane k = bits [k*EW +: EW]
// - in_strb_i      in   DATA_WIDTH/8    byte strobes from streamer
// - out_valid_o    out  1               output beat valid
// - out_ready_i    in   1               datapath ready
// - out_data_o     out  DATA_WIDTH      padded beat
// - out_mask_o     out  N_ELEMS         1 = lane holds a real element
// - out_last_row_o out  1               beat is last of its row
// - out_last_o     out  1               beat is last of tensor
// - busy_o         out  1               FSM not IDLE
// - done_o         out  1               one-cycle pulse at tensor end
// - err_o          out  1               strobe error, sticky (SFM_FRAMER_STRB_CHECK_EN only)
// BEHAVIOUR
// - Reset/clear values:
//   - FSM=IDLE; counters=0; out_valid_o=0; out_data_o=0; out_mask_o=0.
//   - out_last_row_o=0; out_last_o=0; busy_o=0; done_o=0; err_o=0.
//   - A reset or clear mid-tensor discards the held beat and all progress.
// - FSM:
//   - IDLE -> RUN on start_i with row_len_i!=0 and n_rows_i!=0.
//   - IDLE -> DONE on start_i with either field 0. No beats are taken; done_o pulses the next cycle.
//   - RUN -> DRAIN when the final input beat of the tensor is accepted.
//   - DRAIN -> DONE when that beat is accepted at the output.
//   - DONE -> IDLE unconditionally; done_o=1 only in DONE.
//   - start_i is ignored outside IDLE.
// - Counters:
//   - rem = elements left in the current row, loaded with row_len at row start.
//   - row = rows left, loaded with n_rows.
//   - Per accepted beat: v = min(N_ELEMS, rem).
//   - If rem<=N_ELEMS: rem<=row_len and row<=row-1. Otherwise rem<=rem-N_ELEMS.
//   - Rows never share a beat: each row starts at lane 0. Row striding is done upstream.
// - Lane k output:
//   - data = in lane k if k<v, else PAD_VALUE.
//   - out_mask_o[k] = (k<v).
// - Flags:
//   - out_last_row_o = (rem<=N_ELEMS).
//   - out_last_o = out_last_row_o & (row==1).
// - Handshake:
//   - One output register with 1-cycle latency and full throughput.
//   - in_ready_o = (state==RUN) & (~out_valid_o | out_ready_i).
//   - Simultaneous output pop and input push in the same cycle keeps out_valid_o=1 and loads the new beat.
//   - Outputs are held stable while out_valid_o & ~out_ready_i.
//   - in_ready_o=0 in IDLE, DRAIN and DONE; beats offered there are not consumed.
// CONFIGURATION
// - SFM_FRAMER_STRB_CHECK_EN defined:
//   - On every accepted beat, all strobe bytes covering lanes k<v must be 1.
//   - Otherwise err_o is set and stays set until reset, clear, or the next accepted start_i.
//   - Data and flags are unaffected.
// - Not defined: in_strb_i is unused, err_o is tied to 0, and no check logic is built.
// TESTING
// - row_len=8, n_rows=2, always ready -> 2 beats, mask=8'hFF, last_row=1 on both, last=1 on beat 2; done_o 2 cycles after beat 2 accepted.
// - row_len=10, n_rows=1 -> beat1 mask 8'hFF last_row=0; beat2 mask 8'h03, lanes 2..7=16'hFF80, last=1.
// - row_len=5, n_rows=3, out_ready_i toggling 1/0 -> exactly 3 beats, data held while stalled, no loss or duplication.
// - rst_i asserted after beat 1 of row_len=16,n_rows=4 -> next cycle out_valid_o=0, busy_o=0; a fresh start completes correctly.
// - start with n_rows=0 -> no in_ready_o, done_o pulse one cycle after start; STRB_CHECK_EN with row_len=3 and strobe 16'h001F -> err_o=1.

Source files
------------

// File: rtl/sfm_stream_row_framer_if.sv
// Beat-level handshake bundle between the softmax streamer, the row framer and the datapath.
// The slave modport is the framer's view; the master modport is the surrounding environment.
interface sfm_stream_row_framer_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ELEM_WIDTH = 16
);
    localparam int unsigned N_ELEMS = DATA_WIDTH / ELEM_WIDTH;

    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [DATA_WIDTH-1:0]   in_data_i;
    logic [DATA_WIDTH/8-1:0] in_strb_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DATA_WIDTH-1:0]   out_data_o;
    logic [N_ELEMS-1:0]      out_mask_o;
    logic                    out_last_row_o;
    logic                    out_last_o;

    modport slave (
        input  in_valid_i, in_data_i, in_strb_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_mask_o, out_last_row_o, out_last_o
    );

    modport master (
        output in_valid_i, in_data_i, in_strb_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_mask_o, out_last_row_o, out_last_o
    );
endinterface

// File: rtl/sfm_stream_row_framer.sv
// Frames streamer beats into rows of row_len elements, padding unused lanes with -inf.
// Optional strobe coverage check is enabled by defining SFM_FRAMER_STRB_CHECK_EN.
module sfm_stream_row_framer #(
    parameter int unsigned           DATA_WIDTH = 128,
    parameter int unsigned           ELEM_WIDTH = 16,
    parameter int unsigned           LEN_WIDTH  = 16,
    parameter logic [ELEM_WIDTH-1:0] PAD_VALUE  = 16'hFF80
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] row_len_i,
    input  logic [LEN_WIDTH-1:0] n_rows_i,
    sfm_stream_row_framer_if.slave bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);
    localparam int unsigned N_ELEMS = DATA_WIDTH / ELEM_WIDTH;
    localparam int unsigned STRB_W  = DATA_WIDTH / 8;
    localparam int unsigned BPL     = ELEM_WIDTH / 8;
    localparam int unsigned VW      = $clog2(N_ELEMS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [LEN_WIDTH-1:0]   row_q, row_d;
    logic [LEN_WIDTH-1:0]   row_len_q, row_len_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [N_ELEMS-1:0]     out_mask_q, out_mask_d;
    logic                   out_last_row_q, out_last_row_d;
    logic                   out_last_q, out_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   in_ready_s;
    logic                   in_fire_s;
    logic                   out_fire_s;
    logic                   start_fire_s;
    logic                   cfg_zero_s;
    logic                   rem_le_n_s;
    logic                   final_beat_s;
    logic [VW-1:0]          v_s;
    logic [DATA_WIDTH-1:0]  pad_data_s;
    logic [N_ELEMS-1:0]     mask_s;

    assign in_ready_s   = (state_q == ST_RUN) & (~out_valid_q | bus.out_ready_i);
    assign in_fire_s    = bus.in_valid_i & in_ready_s;
    assign out_fire_s   = out_valid_q & bus.out_ready_i;
    assign start_fire_s = start_i & (state_q == ST_IDLE);
    assign cfg_zero_s   = (row_len_i == {LEN_WIDTH{1'b0}}) | (n_rows_i == {LEN_WIDTH{1'b0}});
    assign rem_le_n_s   = (rem_q <= LEN_WIDTH'(N_ELEMS));
    assign final_beat_s = rem_le_n_s & (row_q == LEN_WIDTH'(1));
    assign v_s          = rem_le_n_s ? rem_q[VW-1:0] : VW'(N_ELEMS);

    // Lane selection: real elements below v, pad value above
    always_comb begin
        mask_s     = {N_ELEMS{1'b0}};
        pad_data_s = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < N_ELEMS; k++) begin
            if (VW'(k) < v_s) begin
                mask_s[k]                            = 1'b1;
                pad_data_s[k*ELEM_WIDTH +: ELEM_WIDTH] = bus.in_data_i[k*ELEM_WIDTH +: ELEM_WIDTH];
            end else begin
                mask_s[k]                            = 1'b0;
                pad_data_s[k*ELEM_WIDTH +: ELEM_WIDTH] = PAD_VALUE;
            end
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_fire_s) begin
                    state_d = cfg_zero_s ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_fire_s && final_beat_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Row/element counters and the single output register
    always_comb begin
        rem_d          = rem_q;
        row_d          = row_q;
        row_len_d      = row_len_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_mask_d     = out_mask_q;
        out_last_row_d = out_last_row_q;
        out_last_d     = out_last_q;

        if (start_fire_s) begin
            rem_d     = row_len_i;
            row_d     = n_rows_i;
            row_len_d = row_len_i;
        end else if (in_fire_s) begin
            if (rem_le_n_s) begin
                rem_d = row_len_q;
                row_d = row_q - LEN_WIDTH'(1);
            end else begin
                rem_d = rem_q - LEN_WIDTH'(N_ELEMS);
            end
        end else begin
            rem_d = rem_q;
        end

        // A push wins over a pop so back-to-back beats keep full throughput
        if (in_fire_s) begin
            out_valid_d    = 1'b1;
            out_data_d     = pad_data_s;
            out_mask_d     = mask_s;
            out_last_row_d = rem_le_n_s;
            out_last_d     = final_beat_s;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q        <= ST_IDLE;
            rem_q          <= {LEN_WIDTH{1'b0}};
            row_q          <= {LEN_WIDTH{1'b0}};
            row_len_q      <= {LEN_WIDTH{1'b0}};
            out_valid_q    <= 1'b0;
            out_data_q     <= {DATA_WIDTH{1'b0}};
            out_mask_q     <= {N_ELEMS{1'b0}};
            out_last_row_q <= 1'b0;
            out_last_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            row_q          <= row_d;
            row_len_q      <= row_len_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_mask_q     <= out_mask_d;
            out_last_row_q <= out_last_row_d;
            out_last_q     <= out_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

`ifdef SFM_FRAMER_STRB_CHECK_EN
    logic              err_q, err_d;
    logic [STRB_W-1:0] strb_req_s;

    // Strobe bytes that must be set: every byte of every lane below v
    always_comb begin
        strb_req_s = {STRB_W{1'b0}};
        for (int b = 0; b < STRB_W; b++) begin
            strb_req_s[b] = (VW'(b / BPL) < v_s);
        end
        if (start_fire_s) begin
            err_d = 1'b0;
        end else if (in_fire_s && ((bus.in_strb_i & strb_req_s) != strb_req_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Sticky strobe error flag
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign bus.in_ready_o     = in_ready_s;
    assign bus.out_valid_o    = out_valid_q;
    assign bus.out_data_o     = out_data_q;
    assign bus.out_mask_o     = out_mask_q;
    assign bus.out_last_row_o = out_last_row_q;
    assign bus.out_last_o     = out_last_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
endmodule
